branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
//  EX-stage companion to the 2-bit branch predictor. Queues every predicted branch leaving IF/ID,
//  matches it in order against the EX resolution, raises a one-cycle pipeline flush with the
//  correct redirect PC on mispredict, and returns a training update to the predictor table.
//  Keeps saturating branch/mispredict statistics for the performance counters.
// PARAMETERS
//  XLEN     32  address/data width
//  DEPTH    4   in-flight prediction FIFO entries (power of 2, >=2; covers IF->EX distance)
//  IDX_W    5   predictor table index width (index = pc[IDX_W-1:0], matches 32-entry table)
//  CNT_W    16  statistics counter width
// PORTS
//  clk             in   1      rising-edge clock
//  reset           in   1      synchronous, active-low
//  pred_valid      in   1      predicted branch enters queue this cycle
//  pred_pc         in   XLEN   PC of that branch
//  pred_taken      in   1      predictor direction
//  pred_target     in   XLEN   target fetched if predicted taken
//  resolve_valid   in   1      EX resolves the oldest branch this cycle
//  actual_taken    in   1      EX direction
//  actual_target   in   XLEN   EX-computed target
//  flush           out  1      kill IF/ID/ID-EX contents (registered, 1-cycle pulse)
//  redirect_valid  out  1      load redirect_pc into PC (same cycle as flush)
//  redirect_pc     out  XLEN   correct next PC
//  upd_valid       out  1      predictor training strobe (registered)
//  upd_index       out  IDX_W  table entry to train
//  upd_taken       out  1      actual outcome for training
//  fifo_full       out  1      queue holds DEPTH entries
//  fifo_empty      out  1      queue holds 0 entries
//  err_sticky      out  1      resolve-on-empty or push-on-full seen since reset
//  branch_count    out  CNT_W  resolved branches, saturating
//  mispred_count   out  CNT_W  mispredicted branches, saturating
// BEHAVIOUR
//  - Reset (reset==0 at posedge): all outputs 0, fifo_empty=1, rd/wr ptrs and occupancy 0, entries don't-care.
//  - Queue: circular FIFO, wr/rd ptrs log2(DEPTH) bits wrapping modulo DEPTH, occupancy counter 0..DEPTH.
//  - Push: pred_valid & ~full & ~flush_now -> store {pc,taken,target} at wr_ptr.
//  - Pop: resolve_valid & ~empty -> compare head vs actual, combinational; results registered.
//  - Mispredict = (head.taken != actual_taken) | (actual_taken & head.target != actual_target).
//  - Cycle N+1 after a mispredicting pop: flush=1, redirect_valid=1,
//    redirect_pc = actual_taken ? actual_target : head.pc + 4 (XLEN wrap, no carry out).
//  - flush_now (internal, same cycle N) clears FIFO: ptrs and occupancy to 0; all younger
//    entries are wrong-path. A pred_valid in cycle N is dropped (wrong-path), not an error.
//  - Every pop (correct or not): cycle N+1 upd_valid=1, upd_index=head.pc[IDX_W-1:0], upd_taken=actual_taken.
//  - Simultaneous push+pop, no mispredict: both happen, occupancy unchanged; legal when full.
//  - Push when full and no pop: entry dropped, err_sticky=1. Resolve when empty: ignored,
//    no flush/upd, err_sticky=1. err_sticky cleared only by reset.
//  - branch_count +1 per pop, mispred_count +1 per mispredict; both hold at all-ones.
//  - Back-to-back mispredicts impossible (FIFO cleared) except new push after flush; each
//    mispredict yields exactly one flush pulse.
//  - Reset asserted mid-operation overrides everything next edge; no pending flush survives.
// STRUCTURE
//  - Package bp_pkg: XLEN, IDX_W defaults; typedef struct packed {pc, taken, target} bp_entry_t.
//  - One sub-module: bp_inflight_fifo (generic sync FIFO, push/pop/clear, full/empty, count).
//  - Top holds compare logic, output registers and statistics counters.
// TESTING
//  1 Reset: hold reset=0 3 cycles with pred_valid=1 -> all outputs 0, fifo_empty=1, counts 0.
//  2 Correct predict: push pc=0x40 taken=1 tgt=0x80; resolve taken=1 tgt=0x80 -> flush=0,
//    next cycle upd_valid=1 upd_index=0 upd_taken=1, branch_count=1, mispred_count=0.
//  3 Direction miss: push pc=0x104 taken=1, push pc=0x110; resolve taken=0 -> next cycle
//    flush=1 redirect_pc=0x108 upd_index=4 upd_taken=0, fifo_empty=1 (0x110 discarded).
//  4 Target miss: push pc=0x20 taken=1 tgt=0x200; resolve taken=1 tgt=0x300 -> flush=1, redirect_pc=0x300.
//  5 Full/empty: 4 pushes -> fifo_full=1; 5th push dropped, err_sticky=1; push+pop when full
//    keeps full; resolve on empty -> no upd_valid, err_sticky stays 1.
//  6 Saturation (CNT_W=4): 17 mispredicts -> mispred_count=15; redirect 0xFFFFFFFC+4 wraps to 0.

Source files
------------

// File: rtl/bp_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bp_pkg
// Description : Shared types and defaults for the branch resolve datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package bp_pkg;

    localparam int c_xlen  = 32;
    localparam int c_idx_w = 5;

    typedef struct packed {
        logic [c_xlen-1:0] pc;
        logic              taken;
        logic [c_xlen-1:0] target;
    } bp_entry_t;

    // Fall-through address of a branch; wraps at the top of the address space.
    function automatic logic [c_xlen-1:0] next_seq_pc(input logic [c_xlen-1:0] pc);
        return pc + c_xlen'(4);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bp_inflight_fifo.sv
`default_nettype none
// ============================================================================
// Module      : bp_inflight_fifo
// Description : Generic synchronous circular FIFO with push/pop/clear.
// Revision    : 1.0 - initial release
// ============================================================================
module bp_inflight_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int c_ptr_w = $clog2(DEPTH);

    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_count;
    logic               w_do_push;
    logic               w_do_pop;

    assign full      = (r_count == (c_ptr_w+1)'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign rd_data   = r_mem[r_rd_ptr];
    // A push into a full queue is only possible when the head leaves the same cycle.
    assign w_do_push = push & (~full | pop) & ~clear;
    assign w_do_pop  = pop & ~empty & ~clear;

    always_ff @(posedge clk) begin
        if (!reset || clear) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            if (w_do_push && !w_do_pop)
                r_count <= r_count + (c_ptr_w+1)'(1);
            else if (!w_do_push && w_do_pop)
                r_count <= r_count - (c_ptr_w+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_do_push) r_mem[r_wr_ptr] <= wr_data;
    end

endmodule
`default_nettype wire

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Matches queued branch predictions against EX resolution,
//               raises flush/redirect and predictor training updates.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit
    import bp_pkg::*;
#(
    parameter int XLEN  = c_xlen,
    parameter int DEPTH = 4,
    parameter int IDX_W = c_idx_w,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pred_valid,
    input  logic [XLEN-1:0]  pred_pc,
    input  logic             pred_taken,
    input  logic [XLEN-1:0]  pred_target,
    input  logic             resolve_valid,
    input  logic             actual_taken,
    input  logic [XLEN-1:0]  actual_target,
    output logic             flush,
    output logic             redirect_valid,
    output logic [XLEN-1:0]  redirect_pc,
    output logic             upd_valid,
    output logic [IDX_W-1:0] upd_index,
    output logic             upd_taken,
    output logic             fifo_full,
    output logic             fifo_empty,
    output logic             err_sticky,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] mispred_count
);

    bp_entry_t               w_new_entry;
    bp_entry_t               w_head;
    logic                    w_full;
    logic                    w_empty;
    logic [$clog2(DEPTH):0]  w_count;
    logic                    w_pop;
    logic                    w_push;
    logic                    w_mispredict;
    logic                    w_err_now;

    logic                    r_flush;
    logic [XLEN-1:0]         r_redirect_pc;
    logic                    r_upd_valid;
    logic [IDX_W-1:0]        r_upd_index;
    logic                    r_upd_taken;
    logic                    r_err_sticky;
    logic [CNT_W-1:0]        r_branch_count;
    logic [CNT_W-1:0]        r_mispred_count;

    assign w_new_entry = '{pc: pred_pc, taken: pred_taken, target: pred_target};

    bp_inflight_fifo #(
        .WIDTH ($bits(bp_entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (w_push),
        .pop     (w_pop),
        .clear   (w_mispredict),
        .wr_data (w_new_entry),
        .rd_data (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (w_count)
    );

    assign w_pop        = resolve_valid & (w_count != '0);
    assign w_mispredict = w_pop & ((w_head.taken != actual_taken) |
                                   (actual_taken & (w_head.target != actual_target)));
    // Anything arriving alongside a mispredict is wrong-path and silently dropped.
    assign w_push       = pred_valid & ~w_mispredict & (~w_full | w_pop);
    assign w_err_now    = (resolve_valid & w_empty) | (pred_valid & w_full & ~w_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_flush         <= 1'b0;
            r_redirect_pc   <= '0;
            r_upd_valid     <= 1'b0;
            r_upd_index     <= '0;
            r_upd_taken     <= 1'b0;
            r_err_sticky    <= 1'b0;
            r_branch_count  <= '0;
            r_mispred_count <= '0;
        end else begin
            r_flush     <= w_mispredict;
            r_upd_valid <= w_pop;
            if (w_err_now) r_err_sticky <= 1'b1;
            if (w_pop) begin
                r_upd_index <= w_head.pc[IDX_W-1:0];
                r_upd_taken <= actual_taken;
                if (r_branch_count != '1) r_branch_count <= r_branch_count + CNT_W'(1);
            end
            if (w_mispredict) begin
                r_redirect_pc <= actual_taken ? actual_target : next_seq_pc(w_head.pc);
                if (r_mispred_count != '1) r_mispred_count <= r_mispred_count + CNT_W'(1);
            end
        end
    end

    assign flush          = r_flush;
    assign redirect_valid = r_flush;
    assign redirect_pc    = r_redirect_pc;
    assign upd_valid      = r_upd_valid;
    assign upd_index      = r_upd_index;
    assign upd_taken      = r_upd_taken;
    assign fifo_full      = w_full;
    assign fifo_empty     = w_empty;
    assign err_sticky     = r_err_sticky;
    assign branch_count   = r_branch_count;
    assign mispred_count  = r_mispred_count;

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Directed and randomized bench against a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

    localparam int DEPTH = 4;
    localparam int CNT_W = 4;
    localparam int SAT   = (1 << CNT_W) - 1;

    logic        clk = 1'b0;
    logic        reset;
    logic        pred_valid;
    logic [31:0] pred_pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        resolve_valid;
    logic        actual_taken;
    logic [31:0] actual_target;
    logic        flush;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [4:0]  upd_index;
    logic        upd_taken;
    logic        fifo_full;
    logic        fifo_empty;
    logic        err_sticky;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispred_count;

    always #5 clk = ~clk;

    branch_resolve_unit #(
        .XLEN  (32),
        .DEPTH (DEPTH),
        .IDX_W (5),
        .CNT_W (CNT_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .pred_valid     (pred_valid),
        .pred_pc        (pred_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .resolve_valid  (resolve_valid),
        .actual_taken   (actual_taken),
        .actual_target  (actual_target),
        .flush          (flush),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .upd_valid      (upd_valid),
        .upd_index      (upd_index),
        .upd_taken      (upd_taken),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .err_sticky     (err_sticky),
        .branch_count   (branch_count),
        .mispred_count  (mispred_count)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    typedef struct {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] tgt;
    } pred_t;

    pred_t       q[$];
    logic        m_flush;
    logic        m_upd_valid;
    logic        m_upd_taken;
    logic        m_err;
    logic [31:0] m_rpc;
    logic [4:0]  m_idx;
    int          m_bc;
    int          m_mc;

    // Model update for the edge just taken, using the inputs that were applied to it.
    task automatic model_edge();
        int    n;
        bit    popd;
        bit    mis;
        pred_t h;
        pred_t e;
        if (!reset) begin
            q.delete();
            m_flush = 0; m_upd_valid = 0; m_err = 0; m_bc = 0; m_mc = 0;
        end else begin
            n    = q.size();
            popd = resolve_valid && (n > 0);
            mis  = 0;
            m_flush = 0;
            m_upd_valid = 0;
            if (resolve_valid && n == 0) m_err = 1;
            if (popd) begin
                h = q[0];
                mis = (h.taken != actual_taken) || (actual_taken && (h.tgt != actual_target));
                m_upd_valid = 1;
                m_idx = h.pc[4:0];
                m_upd_taken = actual_taken;
                if (m_bc < SAT) m_bc++;
                if (mis) begin
                    if (m_mc < SAT) m_mc++;
                    m_flush = 1;
                    m_rpc = actual_taken ? actual_target : h.pc + 32'd4;
                end
            end
            if (mis) begin
                q.delete();
            end else begin
                if (popd) void'(q.pop_front());
                if (pred_valid) begin
                    if (n < DEPTH || popd) begin
                        e.pc = pred_pc; e.taken = pred_taken; e.tgt = pred_target;
                        q.push_back(e);
                    end else begin
                        m_err = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        check("flush", 32'(flush), 32'(m_flush));
        check("redirect_valid", 32'(redirect_valid), 32'(m_flush));
        if (m_flush) check("redirect_pc", redirect_pc, m_rpc);
        check("upd_valid", 32'(upd_valid), 32'(m_upd_valid));
        if (m_upd_valid) begin
            check("upd_index", 32'(upd_index), 32'(m_idx));
            check("upd_taken", 32'(upd_taken), 32'(m_upd_taken));
        end
        check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
        check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
        check("err_sticky", 32'(err_sticky), 32'(m_err));
        check("branch_count", 32'(branch_count), m_bc);
        check("mispred_count", 32'(mispred_count), m_mc);
    endtask

    task automatic cyc(input logic pv, input logic [31:0] ppc, input logic pt,
                       input logic [31:0] ptgt, input logic rv, input logic at,
                       input logic [31:0] atgt);
        pred_valid = pv; pred_pc = ppc; pred_taken = pt; pred_target = ptgt;
        resolve_valid = rv; actual_taken = at; actual_target = atgt;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        cyc(0, 0, 0, 0, 0, 0, 0);
        reset = 1'b1;
    endtask

    initial begin
        reset = 1'b0;
        pred_valid = 0; pred_pc = 0; pred_taken = 0; pred_target = 0;
        resolve_valid = 0; actual_taken = 0; actual_target = 0;
        m_rpc = 0; m_idx = 0; m_upd_taken = 0;

        // Reset held with pred_valid active
        repeat (3) cyc(1, 32'h40, 1, 32'h80, 0, 0, 0);
        check("rst_flush", 32'(flush), 0);
        check("rst_empty", 32'(fifo_empty), 1);
        check("rst_bc", 32'(branch_count), 0);
        reset = 1'b1;

        // Correct prediction
        cyc(1, 32'h40, 1, 32'h80, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h80);
        check("t2_flush", 32'(flush), 0);
        check("t2_upd_valid", 32'(upd_valid), 1);
        check("t2_upd_index", 32'(upd_index), 0);
        check("t2_upd_taken", 32'(upd_taken), 1);
        check("t2_bc", 32'(branch_count), 1);
        check("t2_mc", 32'(mispred_count), 0);

        // Direction miss discards the younger entry
        cyc(1, 32'h104, 1, 32'h200, 0, 0, 0);
        cyc(1, 32'h110, 0, 32'h0, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 32'h0);
        check("t3_flush", 32'(flush), 1);
        check("t3_redirect_pc", redirect_pc, 32'h108);
        check("t3_upd_index", 32'(upd_index), 4);
        check("t3_upd_taken", 32'(upd_taken), 0);
        check("t3_empty", 32'(fifo_empty), 1);

        // Target miss
        cyc(1, 32'h20, 1, 32'h200, 0, 0, 0);
        cyc(0, 0, 0, 0, 1, 1, 32'h300);
        check("t4_flush", 32'(flush), 1);
        check("t4_redirect_pc", redirect_pc, 32'h300);

        // Full / empty / error handling
        do_reset();
        for (int i = 0; i < 4; i++) cyc(1, 32'(i * 4), 0, 0, 0, 0, 0);
        check("t5_full", 32'(fifo_full), 1);
        cyc(1, 32'h50, 0, 0, 0, 0, 0);
        check("t5_err", 32'(err_sticky), 1);
        cyc(1, 32'h60, 0, 0, 1, 0, 0);
        check("t5_full_pushpop", 32'(fifo_full), 1);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0);
        cyc(0, 0, 0, 0, 1, 0, 0);
        check("t5_empty_no_upd", 32'(upd_valid), 0);
        check("t5_err_hold", 32'(err_sticky), 1);

        // Counter saturation and fall-through wrap
        do_reset();
        for (int i = 0; i < 17; i++) begin
            cyc(1, (i == 16) ? 32'hFFFF_FFFC : 32'(32'h100 + i * 8), 1, 32'h40, 0, 0, 0);
            cyc(0, 0, 0, 0, 1, 0, 0);
        end
        check("t6_mc_sat", 32'(mispred_count), 15);
        check("t6_wrap", redirect_pc, 0);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 199) != 0);
            cyc(($urandom_range(0, 9) < 6), $urandom() & 32'hFFFF_FFFC, 1'($urandom_range(0, 1)),
                32'($urandom_range(1, 2)) << 4, ($urandom_range(0, 1) == 1),
                1'($urandom_range(0, 1)), 32'($urandom_range(1, 2)) << 4);
        end
        reset = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
